unsadd_run_ctrl: RTL

//  Job sequencer for the 8-input unary non-scaled adder (uNSADD8).
//  - Accepts one job: eight W-bit binary probabilities.
//  - Clears the adder, then generates eight stochastic bitstreams with a shared LFSR SNG.
//  - Feeds the adder for one full LFSR period and counts the adder's output ones.
//  - Returns the count as a binary result over a valid/ready handshake.

---
 rtl/unsadd_run_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/unsadd_run_ctrl.sv
// unsadd_run_ctrl: sequences one uNSADD8 job - clear adder, stream LFSR-generated bits
// for one full LFSR period, count adder output ones, return the count over valid/ready.
module unsadd_run_ctrl #(
    parameter int             W    = 8,
    parameter logic [W-1:0]   TAPS = 8'hB8,
    parameter logic [W-1:0]   SEED = 8'h01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [8*W-1:0]   req_prob,
    input  logic             abort,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_cnt,
    output logic             busy,
    output logic             add_rst_n,
    output logic [7:0]       add_in,
    input  logic             add_out
);
    localparam logic [W-1:0] LEN   = '1;
    localparam logic [W-1:0] SEED0 = (SEED == '0) ? W'(1) : SEED;

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   lfsr_q, lfsr_d;
    logic [W-1:0]   cyc_q, cyc_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [8*W-1:0] prob_q, prob_d;
    logic           add_rst_n_q, add_rst_n_d;
    logic [7:0]     lane_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED0;
            cyc_q       <= '0;
            cnt_q       <= '0;
            prob_q      <= '0;
            add_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cyc_q       <= cyc_d;
            cnt_q       <= cnt_d;
            prob_q      <= prob_d;
            add_rst_n_q <= add_rst_n_d;
        end
    end

    // The first RUN sample is skipped: the adder output lags its input by one cycle.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cyc_d   = cyc_q;
        cnt_d   = cnt_q;
        prob_d  = prob_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    prob_d  = req_prob;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                lfsr_d  = SEED0;
                cyc_d   = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                lfsr_d  = {1'b0, lfsr_q[W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
                cyc_d   = cyc_q + W'(1);
                cnt_d   = cnt_q + W'(add_out && (cyc_q != '0));
                state_d = (cyc_q == LEN - W'(1)) ? DRAIN : RUN;
            end
            DRAIN: begin
                cnt_d   = cnt_q + W'(add_out);
                state_d = DONE;
            end
            DONE:    state_d = res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) state_d = IDLE;
        add_rst_n_d = (state_d != CLEAR);
    end

    for (genvar g = 0; g < 8; g++) begin : g_lane
        localparam int R = g % W;
        logic [2*W-1:0] dbl;
        logic [W-1:0]   rn;
        assign dbl          = {lfsr_q, lfsr_q} >> (W - R);
        assign rn           = dbl[W-1:0];
        assign lane_bits[g] = prob_q[g*W +: W] >= rn;
    end

    assign add_in    = (state_q == RUN && !abort) ? lane_bits : 8'h00;
    assign req_ready = (state_q == IDLE);
    assign res_valid = (state_q == DONE) && !abort;
    assign busy      = (state_q != IDLE);
    assign res_cnt   = cnt_q;
    assign add_rst_n = add_rst_n_q;
endmodule
